// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage data-memory request bus between pipeline and SRAM controller
interface sram_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store responder over a 16-bit SRAM with programmable wait states
module sram_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_OFFSET = 1024
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    mem,
    output logic [17:0]         sram_addr,
    output logic [15:0]         sram_dq_out,
    input  logic [15:0]         sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] idx_lat;
    logic [15:0] wdata_hi;
    logic        op_write;
    logic [31:0] read_data_q;

    logic        req;
    logic        last;
    logic [31:0] addr_diff;
    logic [16:0] idx_in;
    logic        unused_addr_bits;

    assign req       = mem.mem_r_en | mem.mem_w_en;
    assign last      = (cnt == 4'(WAIT_CYCLES - 1));
    // Word index wraps modulo 2^17 for addresses below the SRAM window.
    assign addr_diff = mem.address - 32'(ADDR_OFFSET);
    assign idx_in    = addr_diff[18:2];
    assign unused_addr_bits = ^{addr_diff[31:19], addr_diff[1:0]};

    assign mem.ready     = ~(req & (state != DONE));
    assign mem.read_data = read_data_q;

    // Pin outputs are loaded on the edge that enters each state so they are
    // stable for the whole LO/HI window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_lat     <= 17'd0;
            wdata_hi    <= 16'd0;
            op_write    <= 1'b0;
            read_data_q <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_lat     <= idx_in;
                        wdata_hi    <= mem.write_data[31:16];
                        op_write    <= mem.mem_w_en;
                        cnt         <= 4'd0;
                        state       <= LO;
                        sram_addr   <= {idx_in, 1'b0};
                        sram_dq_out <= mem.mem_w_en ? mem.write_data[15:0] : 16'd0;
                        sram_dq_oe  <= mem.mem_w_en;
                        sram_we_n   <= ~mem.mem_w_en;
                    end
                end
                LO: begin
                    if (last) begin
                        cnt         <= 4'd0;
                        state       <= HI;
                        sram_addr   <= {idx_lat, 1'b1};
                        sram_dq_out <= op_write ? wdata_hi : 16'd0;
                        if (!op_write) read_data_q[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt         <= 4'd0;
                        state       <= DONE;
                        sram_addr   <= 18'd0;
                        sram_dq_out <= 16'd0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        if (!op_write) read_data_q[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed vector bench for sram_controller
module tb_sram_controller;

    logic clk;
    logic rst;

    sram_controller_if m2 ();
    sram_controller_if m1 ();
    sram_controller_if m15 ();

    logic [17:0] sram_addr, sram_addr1, sram_addr15;
    logic [15:0] sram_dq_out, sram_dq_out1, sram_dq_out15;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe, sram_dq_oe1, sram_dq_oe15;
    logic        sram_we_n, sram_we_n1, sram_we_n15;

    sram_controller #(.WAIT_CYCLES(2), .ADDR_OFFSET(1024)) dut (
        .clk(clk), .rst(rst), .mem(m2),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1), .ADDR_OFFSET(1024)) dut_w1 (
        .clk(clk), .rst(rst), .mem(m1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(16'h1234),
        .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
    );

    sram_controller #(.WAIT_CYCLES(15), .ADDR_OFFSET(1024)) dut_w15 (
        .clk(clk), .rst(rst), .mem(m15),
        .sram_addr(sram_addr15), .sram_dq_out(sram_dq_out15), .sram_dq_in(16'h1234),
        .sram_dq_oe(sram_dq_oe15), .sram_we_n(sram_we_n15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous write, asynchronous read, cleared on reset.
    logic [15:0] sram_mem [0:255];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 16'd0;
        end else if (!sram_we_n) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = sram_mem[sram_addr[7:0]];

    typedef struct {
        logic        rst;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_ready;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        logic        e_oe;
        logic        e_we_n;
        logic [31:0] e_rd;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mkv(logic rs, logic r, logic w, logic [31:0] a, logic [31:0] wd,
                                 logic rdy, logic [17:0] ad, logic [15:0] dq, logic oe,
                                 logic we_n, logic [31:0] rd);
        vec_t v;
        v.rst = rs; v.r = r; v.w = w; v.a = a; v.wd = wd;
        v.e_ready = rdy; v.e_addr = ad; v.e_dq = dq; v.e_oe = oe; v.e_we_n = we_n; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = rs;
        m2.mem_r_en = r;
        m2.mem_w_en = w;
        m2.address = a;
        m2.write_data = wd;
        #1;
    endtask

    vec_t tbl [22];
    int   stall;
    logic [17:0] exp_a;

    initial begin
        tbl[0]  = mkv(0, 1, 0, 0,    0,            0, 0, 16'h0,    0, 1, 32'h0);
        tbl[1]  = mkv(0, 1, 0, 0,    0,            0, 0, 16'h0,    0, 1, 32'h0);
        tbl[2]  = mkv(0, 1, 0, 0,    0,            0, 0, 16'h0,    0, 1, 32'h0);
        tbl[3]  = mkv(1, 1, 0, 1032, 0,            0, 0, 16'h0,    0, 1, 32'h0);
        tbl[4]  = mkv(1, 0, 0, 0,    0,            1, 4, 16'h0,    0, 1, 32'h0);
        tbl[5]  = mkv(1, 0, 0, 0,    0,            1, 4, 16'h0,    0, 1, 32'h0);
        tbl[6]  = mkv(1, 0, 0, 0,    0,            1, 5, 16'h0,    0, 1, 32'h0);
        tbl[7]  = mkv(1, 0, 0, 0,    0,            1, 5, 16'h0,    0, 1, 32'h0);
        tbl[8]  = mkv(1, 0, 0, 0,    0,            1, 0, 16'h0,    0, 1, 32'h0);
        tbl[9]  = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 0, 0, 16'h0,    0, 1, 32'h0);
        tbl[10] = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 0, 4, 16'hBEEF, 1, 0, 32'h0);
        tbl[11] = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 0, 4, 16'hBEEF, 1, 0, 32'h0);
        tbl[12] = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 0, 5, 16'hDEAD, 1, 0, 32'h0);
        tbl[13] = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 0, 5, 16'hDEAD, 1, 0, 32'h0);
        tbl[14] = mkv(1, 0, 1, 1032, 32'hDEADBEEF, 1, 0, 16'h0,    0, 1, 32'h0);
        tbl[15] = mkv(1, 0, 0, 0,    0,            1, 0, 16'h0,    0, 1, 32'h0);
        tbl[16] = mkv(1, 1, 0, 1032, 0,            0, 0, 16'h0,    0, 1, 32'h0);
        tbl[17] = mkv(1, 1, 0, 1032, 0,            0, 4, 16'h0,    0, 1, 32'h0);
        tbl[18] = mkv(1, 1, 0, 1032, 0,            0, 4, 16'h0,    0, 1, 32'h0);
        tbl[19] = mkv(1, 1, 0, 1032, 0,            0, 5, 16'h0,    0, 1, 32'h0000BEEF);
        tbl[20] = mkv(1, 1, 0, 1032, 0,            0, 5, 16'h0,    0, 1, 32'h0000BEEF);
        tbl[21] = mkv(1, 1, 0, 1032, 0,            1, 0, 16'h0,    0, 1, 32'hDEADBEEF);

        rst = 1'b0;
        m2.mem_r_en = 0;  m2.mem_w_en = 0;  m2.address = 0;  m2.write_data = 0;
        m1.mem_r_en = 0;  m1.mem_w_en = 0;  m1.address = 0;  m1.write_data = 0;
        m15.mem_r_en = 0; m15.mem_w_en = 0; m15.address = 0; m15.write_data = 0;
        @(posedge clk);

        // Reset, reset-release read, write, read-back
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd);
            chk($sformatf("v%0d ready", i),     32'(m2.ready),   32'(tbl[i].e_ready));
            chk($sformatf("v%0d sram_addr", i), 32'(sram_addr),  32'(tbl[i].e_addr));
            chk($sformatf("v%0d dq_out", i),    32'(sram_dq_out),32'(tbl[i].e_dq));
            chk($sformatf("v%0d dq_oe", i),     32'(sram_dq_oe), 32'(tbl[i].e_oe));
            chk($sformatf("v%0d we_n", i),      32'(sram_we_n),  32'(tbl[i].e_we_n));
            chk($sformatf("v%0d read_data", i), m2.read_data,    tbl[i].e_rd);
        end

        // read_data holds through idle cycles
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("hold%0d read_data", k), m2.read_data, 32'hDEADBEEF);
            chk($sformatf("hold%0d ready", k), 32'(m2.ready), 32'd1);
        end

        // Both enables high: a write, read_data untouched
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 1, 1036, 32'h13572468);
            chk($sformatf("both%0d ready", k), 32'(m2.ready), (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("both%0d read_data", k), m2.read_data, 32'hDEADBEEF);
            if (k >= 1 && k <= 4) begin
                chk($sformatf("both%0d we_n", k), 32'(sram_we_n), 32'd0);
                chk($sformatf("both%0d sram_addr", k), 32'(sram_addr), (k < 3) ? 32'd6 : 32'd7);
                chk($sformatf("both%0d dq_out", k), 32'(sram_dq_out), (k < 3) ? 32'h2468 : 32'h1357);
            end
        end
        drive(1, 0, 0, 0, 0);

        // Back-to-back reads, address changed at DONE
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 0, (k >= 5) ? 32'd1036 : 32'd1032, 0);
            case (k)
                1, 2:  exp_a = 18'd4;
                3, 4:  exp_a = 18'd5;
                7, 8:  exp_a = 18'd6;
                9, 10: exp_a = 18'd7;
                default: exp_a = 18'd0;
            endcase
            chk($sformatf("b2b%0d sram_addr", k), 32'(sram_addr), 32'(exp_a));
            chk($sformatf("b2b%0d ready", k), 32'(m2.ready), (k == 5 || k == 11) ? 32'd1 : 32'd0);
            if (k == 5)  chk("b2b first read_data", m2.read_data, 32'hDEADBEEF);
            if (k == 11) chk("b2b second read_data", m2.read_data, 32'h13572468);
        end
        drive(1, 0, 0, 0, 0);

        // Reset asserted during HI of a write
        for (int k = 0; k < 3; k++) drive(1, 0, 1, 1040, 32'hAAAA5555);
        drive(0, 0, 1, 1040, 32'hAAAA5555);
        chk("rstmid HI we_n", 32'(sram_we_n), 32'd0);
        chk("rstmid HI sram_addr", 32'(sram_addr), 32'd9);
        drive(1, 0, 0, 0, 0);
        chk("rstmid we_n", 32'(sram_we_n), 32'd1);
        chk("rstmid dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rstmid sram_addr", 32'(sram_addr), 32'd0);
        chk("rstmid ready", 32'(m2.ready), 32'd1);
        chk("rstmid read_data", m2.read_data, 32'd0);
        // Idle cycle in IDLE proves the FSM is not still in HI/DONE
        drive(1, 0, 0, 0, 0);
        chk("rstmid idle we_n", 32'(sram_we_n), 32'd1);

        // Stall length for WAIT_CYCLES = 1 and 15
        for (int sel = 0; sel < 2; sel++) begin
            stall = 0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (sel == 0) begin
                    m1.mem_w_en = 1; m1.address = 1024; m1.write_data = 32'h01020304;
                end else begin
                    m15.mem_w_en = 1; m15.address = 1024; m15.write_data = 32'h01020304;
                end
                #1;
                if ((sel == 0) ? m1.ready : m15.ready) break;
                stall++;
            end
            chk(sel == 0 ? "stall W1" : "stall W15", 32'(stall), sel == 0 ? 32'd3 : 32'd31);
            @(negedge clk);
            m1.mem_w_en = 0;
            m15.mem_w_en = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder on the far side of the MEM stage's data-memory request interface. Accepts a 32-bit read or write request (`mem_r_en`/`mem_w_en`, address, store data) and completes it on an external 16-bit SRAM as two half-word accesses with programmable wait states. It drives `ready` low while an access is in flight; the hazard/freeze logic uses `ready` to stall the whole pipeline. It replaces the single-cycle DataMemory behind the MEM stage.

## Interface

Parameters:
- `WAIT_CYCLES`, 2: SRAM cycles per half-word access; legal range 1..15.
- `ADDR_OFFSET`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mem_r_en`  in  1  read request from the MEM stage.
- `mem_w_en`  in  1  write request from the MEM stage.
- `address`  in  32  byte address (ALU result); word aligned.
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  load result.
- `ready`  out  1  0 = access pending, freeze pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_in`  in  16  data returned by SRAM.
- `sram_dq_oe`  out  1  1 = controller drives the SRAM data bus.
- `sram_we_n`  out  1  SRAM write enable, active low.

## Operation

- The state machine has four states: IDLE, LO, HI, DONE. A 4-bit wait counter `cnt` counts within each state.
- **IDLE:**
  - If `mem_w_en | mem_r_en`, latch `address`, `write_data` and the operation, clear `cnt`, and go to LO.
  - If both enables are high, the request is a write.
- **LO:** accesses the low half-word. Increments `cnt`. When `cnt == WAIT_CYCLES-1`, go to HI and clear `cnt`.
- **HI:** accesses the high half-word. Uses the same count rule and then goes to DONE.
- **DONE:** lasts one cycle, then goes to IDLE.
- Address translation:
  - `idx = (addr_latched - ADDR_OFFSET) >> 2`, truncated to 17 bits.
  - `sram_addr = {idx[16:0], 1'b0}` in LO and `{idx[16:0], 1'b1}` in HI.
  - `sram_addr` is 0 in IDLE and DONE.
- Writes:
  - In LO and HI: `sram_dq_oe = 1` and `sram_we_n = 0`.
  - `sram_dq_out = wdata_latched[15:0]` in LO and `[31:16]` in HI.
- Reads:
  - `sram_we_n = 1` and `sram_dq_oe = 0`.
  - On the last cycle of LO (`cnt == WAIT_CYCLES-1`), register `sram_dq_in` into `read_data[15:0]`.
  - On the last cycle of HI, register it into `read_data[31:16]`.
- `read_data` holds its value until overwritten by a later read. Writes never change it.
- `ready = ~((mem_r_en | mem_w_en) & (state != DONE))`. This is combinational, so `ready` drops in the same cycle a request appears.
- Outside a write phase: `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_dq_out = 0`.

## Timing

- Reset values (synchronous, while `rst == 0`):
  - State IDLE, `cnt = 0`, `read_data = 0`, all latches 0.
  - `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
  - `ready` follows its equation, so it is 1 when no request is present.
- Latency for a request first seen in IDLE at cycle 0:
  - `ready = 0` for cycles 0..2·WAIT_CYCLES.
  - `ready = 1` in cycle 2·WAIT_CYCLES+1 (DONE).
  - With the default, `ready` is low for 5 cycles and high in the 6th.
- `read_data` is valid in DONE. The MEM/WB register captures it at the end of that cycle.
- Handshake:
  - The requester holds the request until it sees `ready = 1`.
  - After DONE the FSM returns to IDLE. A request still asserted there is treated as the next instruction's request and starts a new access.
- Because address, data and operation are latched, changing or dropping the inputs mid-access does not alter the access in flight; it still completes through DONE.
- Reset asserted mid-access:
  - Next edge: IDLE, `sram_we_n = 1`, `sram_dq_oe = 0`.
  - The write is partial and `read_data` is cleared.
- `address < ADDR_OFFSET` wraps modulo 2^17 words; no error is flagged.

## Test plan

- **Reset:** hold `rst = 0` for 3 cycles with `mem_r_en = 1`, then release. Required: `read_data = 0`, `sram_we_n = 1` and `sram_dq_oe = 0` during reset, and `ready = 0` from the first cycle after release.
- **Write:**
  - Stimulus: `WAIT_CYCLES = 2`, `mem_w_en = 1`, `address = 1032`, `write_data = 0xDEADBEEF`.
  - Required: `sram_addr = 4` with `dq_out = 0xBEEF` for 2 cycles, then `sram_addr = 5` with `dq_out = 0xDEAD` for 2 cycles.
  - Required: `ready` low for 5 cycles and high in cycle 5.
- **Read:**
  - Stimulus: the SRAM model returns 0xBEEF at half-word 4 and 0xDEAD at half-word 5; read `address = 1032`.
  - Required: `read_data = 0xDEADBEEF` in DONE, and held through 10 further idle cycles.
- **Simultaneous enables:** `mem_r_en = mem_w_en = 1`. Required: write performed (`sram_we_n = 0` in LO/HI) and `read_data` unchanged.
- **Back-to-back:** hold a read after DONE while changing the address to 1036. Required: the second access starts immediately (half-words 6 and 7), with `ready` low again the cycle after DONE.
- **Reset mid-access:** assert `rst = 0` in the HI state of a write. Required: the next cycle is IDLE with `sram_we_n = 1` and `sram_dq_oe = 0`; `WAIT_CYCLES = 1` and `WAIT_CYCLES = 15` give 3- and 31-cycle stalls respectively.
